// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port word RAM between instruction fetch
// and load/store traffic. Data requests win by default. A fetch that has lost
// FETCH_MAX_WAIT decisions in a row wins the next decision unconditionally.
// Every access runs through IDLE -> ACCESS [-> RWAIT -> RESP].
// Ports:
//   iCLK, iRST                     clock, synchronous active-high reset
//   iIF_REQ/iIF_ADDR               fetch request side
//   oIF_GNT/oIF_RVALID/oIF_RDATA   fetch grant pulse, read-valid pulse, read data
//   iDM_REQ/iDM_WE/iDM_ADDR/iDM_WDATA  load/store request side
//   oDM_GNT/oDM_RVALID/oDM_RDATA   data grant pulse, load-valid pulse, load data
//   oDM_ERR                        misaligned data request rejected (pulse)
//   oRAM_CE/oRAM_RD/oRAM_WR        registered RAM strobes
//   oRAM_ADDR/oRAM_DATA            RAM word address and write data
//   iRAM_DATA                      RAM read data, valid the cycle after RD
//   oBUSY                          high whenever the FSM is not in IDLE
module ram_port_arbiter #(
  parameter int unsigned FETCH_MAX_WAIT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIF_REQ,
  input  logic [31:0] iIF_ADDR,
  output logic        oIF_GNT,
  output logic        oIF_RVALID,
  output logic [31:0] oIF_RDATA,
  input  logic        iDM_REQ,
  input  logic        iDM_WE,
  input  logic [31:0] iDM_ADDR,
  input  logic [31:0] iDM_WDATA,
  output logic        oDM_GNT,
  output logic        oDM_RVALID,
  output logic [31:0] oDM_RDATA,
  output logic        oDM_ERR,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [7:0]  oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA,
  output logic        oBUSY
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RWAIT, S_RESP} state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_own_dm;     // current access belongs to the data port
  logic              r_is_store;

  logic              r_if_gnt, r_if_rvalid, r_dm_gnt, r_dm_rvalid, r_dm_err;
  logic              r_ram_ce, r_ram_rd, r_ram_wr, r_busy;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data, r_if_rdata, r_dm_rdata;

  logic              w_if_gnt, w_if_rvalid, w_dm_gnt, w_dm_rvalid, w_dm_err;
  logic              w_ram_ce, w_ram_rd, w_ram_wr, w_busy;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data, w_if_rdata, w_dm_rdata;

  // Arbitration decision, only meaningful while in IDLE
  logic w_idle, w_cnt_full, w_if_win, w_dm_win, w_dm_misal, w_accept;
  assign w_idle     = (r_state == S_IDLE);
  assign w_cnt_full = (r_wait_cnt == CNT_W'(FETCH_MAX_WAIT));
  assign w_if_win   = iIF_REQ && (!iDM_REQ || w_cnt_full);
  assign w_dm_win   = iDM_REQ && !w_if_win;
  assign w_dm_misal = w_dm_win && (iDM_ADDR[1:0] != 2'b00);
  assign w_accept   = w_if_win || (w_dm_win && !w_dm_misal);

  // Upper address bits wrap away; fetch byte-offset bits are don't-care
  logic w_unused;
  assign w_unused = ^{iIF_ADDR[31:10], iIF_ADDR[1:0], iDM_ADDR[31:10]};

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = r_is_store ? S_IDLE : S_RWAIT;
      S_RWAIT:  w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    w_dm_err    = 1'b0;
    w_ram_ce    = 1'b0;
    w_ram_rd    = 1'b0;
    w_ram_wr    = 1'b0;
    w_ram_addr  = '0;
    w_ram_data  = '0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_busy      = (w_next_state != S_IDLE);
    if (w_idle && w_accept) begin
      w_ram_ce   = 1'b1;
      w_ram_wr   = w_dm_win && iDM_WE;
      w_ram_rd   = !(w_dm_win && iDM_WE);
      w_ram_addr = w_if_win ? iIF_ADDR[9:2] : iDM_ADDR[9:2];
      w_ram_data = (w_dm_win && iDM_WE) ? iDM_WDATA : '0;
      w_if_gnt   = w_if_win;
      w_dm_gnt   = w_dm_win;
    end
    w_dm_err = w_idle && w_dm_misal;
    // Read data is captured at the end of RWAIT and presented during RESP
    if (r_state == S_RWAIT) begin
      if (r_own_dm) begin
        w_dm_rvalid = 1'b1;
        w_dm_rdata  = iRAM_DATA;
      end else begin
        w_if_rvalid = 1'b1;
        w_if_rdata  = iRAM_DATA;
      end
    end
  end

  // Output registers, command ownership and fetch-starvation counter
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_ram_ce    <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_busy      <= 1'b0;
      r_own_dm    <= 1'b0;
      r_is_store  <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_if_gnt    <= w_if_gnt;
      r_dm_gnt    <= w_dm_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_dm_rvalid <= w_dm_rvalid;
      r_dm_err    <= w_dm_err;
      r_ram_ce    <= w_ram_ce;
      r_ram_rd    <= w_ram_rd;
      r_ram_wr    <= w_ram_wr;
      r_ram_addr  <= w_ram_addr;
      r_ram_data  <= w_ram_data;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_busy      <= w_busy;
      if (w_idle) begin
        if (w_accept) begin
          r_own_dm   <= w_dm_win;
          r_is_store <= w_dm_win && iDM_WE;
        end
        // A misaligned data win still counts as a fetch loss
        if (!iIF_REQ || w_if_win)  r_wait_cnt <= '0;
        else if (!w_cnt_full)      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  assign oIF_GNT    = r_if_gnt;
  assign oIF_RVALID = r_if_rvalid;
  assign oIF_RDATA  = r_if_rdata;
  assign oDM_GNT    = r_dm_gnt;
  assign oDM_RVALID = r_dm_rvalid;
  assign oDM_RDATA  = r_dm_rdata;
  assign oDM_ERR    = r_dm_err;
  assign oRAM_CE    = r_ram_ce;
  assign oRAM_RD    = r_ram_rd;
  assign oRAM_WR    = r_ram_wr;
  assign oRAM_ADDR  = r_ram_addr;
  assign oRAM_DATA  = r_ram_data;
  assign oBUSY      = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small word-RAM model.
// Unwritten RAM words read back as {24'hA50000, word_index}.
module tb_ram_port_arbiter;

  logic        iCLK, iRST;
  logic        iIF_REQ, oIF_GNT, oIF_RVALID;
  logic [31:0] iIF_ADDR, oIF_RDATA;
  logic        iDM_REQ, iDM_WE, oDM_GNT, oDM_RVALID, oDM_ERR;
  logic [31:0] iDM_ADDR, iDM_WDATA, oDM_RDATA;
  logic        oRAM_CE, oRAM_RD, oRAM_WR, oBUSY;
  logic [7:0]  oRAM_ADDR;
  logic [31:0] oRAM_DATA, iRAM_DATA;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.FETCH_MAX_WAIT(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIF_REQ(iIF_REQ), .iIF_ADDR(iIF_ADDR),
    .oIF_GNT(oIF_GNT), .oIF_RVALID(oIF_RVALID), .oIF_RDATA(oIF_RDATA),
    .iDM_REQ(iDM_REQ), .iDM_WE(iDM_WE), .iDM_ADDR(iDM_ADDR), .iDM_WDATA(iDM_WDATA),
    .oDM_GNT(oDM_GNT), .oDM_RVALID(oDM_RVALID), .oDM_RDATA(oDM_RDATA), .oDM_ERR(oDM_ERR),
    .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
    .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA(oRAM_DATA), .iRAM_DATA(iRAM_DATA),
    .oBUSY(oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // RAM model: stored words are XOR-scrambled so an all-zero array reads as a pattern
  bit [31:0] mem [256];
  always @(posedge iCLK) begin
    if (oRAM_CE && oRAM_WR) mem[oRAM_ADDR] <= oRAM_DATA ^ {24'hA50000, oRAM_ADDR};
    if (oRAM_CE && oRAM_RD) iRAM_DATA <= mem[oRAM_ADDR] ^ {24'hA50000, oRAM_ADDR};
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic test_reset();
    logic [112:0] outs;
    iRST = 1'b1; iIF_REQ = 1'b1; iIF_ADDR = 32'h20;
    iDM_REQ = 1'b1; iDM_WE = 1'b0; iDM_ADDR = 32'h10; iDM_WDATA = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs = {oIF_GNT, oIF_RVALID, oIF_RDATA, oDM_GNT, oDM_RVALID, oDM_RDATA, oDM_ERR,
              oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA, oBUSY};
      checks++;
      if (outs !== '0) begin
        errors++; $display("FAIL reset_outs cycle %0d: got %h exp 0", i, outs);
      end
    end
    iRST = 1'b0;
    tick();
    checks++;
    if ({oDM_GNT, oIF_GNT, oRAM_RD} !== 3'b101) begin
      errors++; $display("FAIL reset_first_gnt: got dm/if/rd %b exp 101", {oDM_GNT, oIF_GNT, oRAM_RD});
    end
    iDM_REQ = 1'b0; iIF_REQ = 1'b0;
    tick(); tick();
    checks++;
    if (oDM_RVALID !== 1'b1 || oDM_RDATA !== 32'hA5000004) begin
      errors++; $display("FAIL reset_first_load: got v=%b d=%h exp v=1 d=a5000004", oDM_RVALID, oDM_RDATA);
    end
    tick();
  endtask

  task automatic test_store_load();
    iDM_REQ = 1'b1; iDM_WE = 1'b1; iDM_ADDR = 32'h14; iDM_WDATA = 32'hDEADBEEF;
    tick();
    checks++;
    if ({oRAM_CE, oRAM_WR, oRAM_RD, oDM_GNT, oIF_GNT} !== 5'b11010 || oRAM_ADDR !== 8'h05 ||
        oRAM_DATA !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_cmd: got ce/wr/rd/dg/ig=%b addr=%h data=%h exp 11010 05 deadbeef",
                         {oRAM_CE, oRAM_WR, oRAM_RD, oDM_GNT, oIF_GNT}, oRAM_ADDR, oRAM_DATA);
    end
    iDM_REQ = 1'b0;
    tick();
    checks++;
    if (oBUSY !== 1'b0 || oRAM_WR !== 1'b0 || oRAM_DATA !== 32'h0) begin
      errors++; $display("FAIL store_done: got busy=%b wr=%b data=%h exp 0 0 0", oBUSY, oRAM_WR, oRAM_DATA);
    end
    iDM_REQ = 1'b1; iDM_WE = 1'b0; iDM_WDATA = 32'h0;
    tick();
    checks++;
    if ({oRAM_CE, oRAM_RD, oRAM_WR, oDM_GNT} !== 4'b1101 || oRAM_ADDR !== 8'h05) begin
      errors++; $display("FAIL load_cmd: got ce/rd/wr/gnt=%b addr=%h exp 1101 05",
                         {oRAM_CE, oRAM_RD, oRAM_WR, oDM_GNT}, oRAM_ADDR);
    end
    iDM_REQ = 1'b0;
    tick();
    checks++;
    if (oDM_RVALID !== 1'b0 || oDM_RDATA !== 32'hA5000004 || oRAM_CE !== 1'b0) begin
      errors++; $display("FAIL load_rwait: got v=%b d=%h ce=%b exp 0 a5000004 0", oDM_RVALID, oDM_RDATA, oRAM_CE);
    end
    tick();
    checks++;
    if (oDM_RVALID !== 1'b1 || oDM_RDATA !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_resp: got v=%b d=%h exp 1 deadbeef", oDM_RVALID, oDM_RDATA);
    end
    tick();
    checks++;
    if (oDM_RVALID !== 1'b0 || oDM_RDATA !== 32'hDEADBEEF || oBUSY !== 1'b0) begin
      errors++; $display("FAIL load_hold: got v=%b d=%h busy=%b exp 0 deadbeef 0", oDM_RVALID, oDM_RDATA, oBUSY);
    end
  endtask

  task automatic test_contention();
    int grants = 0;
    logic exp_f;
    iIF_REQ = 1'b1; iIF_ADDR = 32'h14;
    iDM_REQ = 1'b1; iDM_WE = 1'b0; iDM_ADDR = 32'h10;
    for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
      tick();
      if (oIF_GNT || oDM_GNT) begin
        exp_f = (grants % 5 == 4);
        checks++;
        if (oIF_GNT !== exp_f || oDM_GNT !== !exp_f) begin
          errors++; $display("FAIL contention_order grant %0d: got if=%b dm=%b exp if=%b", grants, oIF_GNT, oDM_GNT, exp_f);
        end
        if (oIF_GNT === 1'b1) begin
          checks++;
          if (dut.r_wait_cnt !== 4'd0) begin
            errors++; $display("FAIL contention_cnt: got %0d exp 0", dut.r_wait_cnt);
          end
        end
        grants++;
      end
    end
    checks++;
    if (grants != 10) begin
      errors++; $display("FAIL contention_timeout: got %0d grants exp 10", grants);
    end
    iIF_REQ = 1'b0; iDM_REQ = 1'b0;
    for (int cyc = 0; cyc < 8 && oBUSY !== 1'b0; cyc++) tick();
    checks++;
    if (oBUSY !== 1'b0 || oIF_RDATA !== 32'hDEADBEEF) begin
      errors++; $display("FAIL contention_fetch_data: got busy=%b d=%h exp 0 deadbeef", oBUSY, oIF_RDATA);
    end
  endtask

  task automatic test_misaligned();
    iDM_REQ = 1'b1; iDM_WE = 1'b0; iDM_ADDR = 32'h22;
    tick();
    checks++;
    if ({oDM_ERR, oRAM_CE, oBUSY, oDM_GNT} !== 4'b1000) begin
      errors++; $display("FAIL misaligned_first: got err/ce/busy/gnt=%b exp 1000", {oDM_ERR, oRAM_CE, oBUSY, oDM_GNT});
    end
    tick();
    checks++;
    if ({oDM_ERR, oRAM_CE, oBUSY} !== 3'b100) begin
      errors++; $display("FAIL misaligned_second: got err/ce/busy=%b exp 100", {oDM_ERR, oRAM_CE, oBUSY});
    end
    iDM_REQ = 1'b0;
    tick();
    checks++;
    if ({oDM_ERR, oRAM_CE, oBUSY} !== 3'b000) begin
      errors++; $display("FAIL misaligned_after: got err/ce/busy=%b exp 000", {oDM_ERR, oRAM_CE, oBUSY});
    end
  endtask

  task automatic test_reset_mid_read();
    iIF_REQ = 1'b1; iIF_ADDR = 32'h40;
    tick();
    checks++;
    if (oIF_GNT !== 1'b1 || oRAM_ADDR !== 8'h10) begin
      errors++; $display("FAIL midrst_gnt: got gnt=%b addr=%h exp 1 10", oIF_GNT, oRAM_ADDR);
    end
    iIF_REQ = 1'b0;
    tick();
    checks++;
    if (oBUSY !== 1'b1) begin
      errors++; $display("FAIL midrst_rwait_busy: got %b exp 1", oBUSY);
    end
    iRST = 1'b1;
    tick();
    checks++;
    if ({oIF_RVALID, oRAM_CE, oBUSY} !== 3'b000 || oIF_RDATA !== 32'h0) begin
      errors++; $display("FAIL midrst_abort: got v/ce/busy=%b d=%h exp 000 0", {oIF_RVALID, oRAM_CE, oBUSY}, oIF_RDATA);
    end
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (oIF_RVALID !== 1'b0 || oIF_RDATA !== 32'h0) begin
        errors++; $display("FAIL midrst_no_rvalid cycle %0d: got v=%b d=%h exp 0 0", i, oIF_RVALID, oIF_RDATA);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [7:0]  exp_a [2];
    addrs[0] = 32'h400; exp_a[0] = 8'h00;
    addrs[1] = 32'h3FC; exp_a[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      iIF_REQ = 1'b1; iIF_ADDR = addrs[k];
      tick();
      checks++;
      if (oIF_GNT !== 1'b1 || oRAM_RD !== 1'b1 || oRAM_ADDR !== exp_a[k]) begin
        errors++; $display("FAIL wrap_addr %0d: got gnt=%b rd=%b addr=%h exp 1 1 %h", k, oIF_GNT, oRAM_RD, oRAM_ADDR, exp_a[k]);
      end
      iIF_REQ = 1'b0;
      tick(); tick();
      checks++;
      if (oIF_RVALID !== 1'b1 || oIF_RDATA !== {24'hA50000, exp_a[k]}) begin
        errors++; $display("FAIL wrap_data %0d: got v=%b d=%h exp 1 %h", k, oIF_RVALID, oIF_RDATA, {24'hA50000, exp_a[k]});
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_contention();
    test_misaligned();
    test_reset_mid_read();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port, word-organised data RAM between the instruction-fetch requester and the load/store requester, which covers both the compressed (CS/CL) and the full-width memory instructions. It sits between the core and the RAM, and owns the RAM command outputs: CE/RD/WR strobes, 8-bit word address and write data. Arbitration is data-priority with a fetch-starvation guard. It sequences every access through a fixed registered state machine and returns read data through a valid-pulse handshake.

## Interface
- FETCH_MAX_WAIT, 4: consecutive arbitration losses after which a pending fetch wins unconditionally (1..15).
- iCLK  in  1  clock, rising edge.
- iRST  in  1  synchronous reset, active-high.
- iIF_REQ  in  1  fetch request, held high until oIF_GNT is seen.
- iIF_ADDR  in  32  fetch byte address.
- oIF_GNT  out  1  one-cycle pulse: fetch command is on the RAM bus this cycle.
- oIF_RVALID  out  1  one-cycle pulse: oIF_RDATA holds fetched word.
- oIF_RDATA  out  32  fetched word, held until next fetch RVALID.
- iDM_REQ  in  1  data request, held high until oDM_GNT or oDM_ERR is seen.
- iDM_WE  in  1  1 = store, 0 = load.
- iDM_ADDR  in  32  data byte address.
- iDM_WDATA  in  32  store data.
- oDM_GNT  out  1  one-cycle pulse: data command is on the RAM bus this cycle.
- oDM_RVALID  out  1  one-cycle pulse: oDM_RDATA holds the loaded word. Loads only.
- oDM_RDATA  out  32  loaded word, held until next load RVALID.
- oDM_ERR  out  1  one-cycle pulse: misaligned data request rejected.
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes, registered.
- oRAM_ADDR  out  8  word address = byte address[9:2].
- oRAM_DATA  out  32  write data. 0 when not writing.
- iRAM_DATA  in  32  RAM read data, valid the cycle after the RD strobe.
- oBUSY  out  1  high in every state except IDLE.

## Operation
- States are IDLE, ACCESS, RWAIT, RESP.
- **IDLE**
  - Samples requests at each rising edge.
  - Winner rule: data wins, unless the fetch-wait counter equals FETCH_MAX_WAIT and iIF_REQ is high, in which case fetch wins.
- **Misaligned data request**
  - Condition: data wins and iDM_ADDR[1:0] != 0.
  - Pulse oDM_ERR next cycle and stay in IDLE. No RAM strobe is issued.
  - This event counts as a fetch loss if iIF_REQ was high.
- **Accepted request**: register the RAM command and go to ACCESS.
- **ACCESS (1 cycle)**
  - oRAM_CE=1.
  - oRAM_RD=1 for a fetch or load; oRAM_WR=1 with oRAM_DATA=iDM_WDATA for a store.
  - oRAM_ADDR is the registered winner address[9:2].
  - Winner's GNT=1.
  - Next state: a store returns to IDLE; a read goes to RWAIT.
- **RWAIT (1 cycle)**
  - Strobes are 0.
  - iRAM_DATA is captured at the end of this cycle into the owner's RDATA register. Go to RESP.
- **RESP (1 cycle)**: owner's RVALID=1; return to IDLE.
- **Fetch-wait counter (4 bits)**
  - Increments, saturating at FETCH_MAX_WAIT, on each IDLE decision where iIF_REQ=1 and fetch loses.
  - Clears on fetch grant, and on any IDLE cycle with iIF_REQ=0.
- Fetch never writes. iIF_ADDR[1:0] is ignored, so fetch is word-aligned by construction.
- Address bits [31:10] are ignored, so addresses wrap modulo 1 KiB.
- Request inputs are ignored outside IDLE. A requester still holding REQ during its GNT cycle is not re-accepted, because the block is no longer in IDLE.

## Timing
- **Reset**
  - All outputs are 0, including RDATA registers, strobes and pulses.
  - State = IDLE, counter = 0.
  - Reset asserted mid-access aborts it: no GNT, RVALID or ERR is issued afterwards, and strobes are 0 the cycle after reset is sampled.
- **Latency from the REQ-sampling edge (end of cycle T)**
  - GNT and RAM strobe in T+1.
  - RVALID in T+3.
  - Earliest next acceptance: IDLE in T+2 for a store, T+4 for a read.
- **Throughput**: one read per 4 cycles, one store per 2 cycles, one ERR per cycle.
- **Simultaneous requests in IDLE**: resolved by the winner rule. The loser stays pending and is re-evaluated at the next IDLE edge.
- RDATA registers change only in the cycle their RVALID rises.

## Test plan
1. **Reset**: hold iRST 3 cycles with both REQs high → all outputs 0 throughout. First GNT appears 1 cycle after iRST falls.
2. **Store then load**
   - Store: iDM_WE=1, addr 0x0000_0014, wdata 0xDEAD_BEEF → T+1 has oRAM_WR=1, oRAM_ADDR=0x05, oRAM_DATA=0xDEADBEEF, oDM_GNT=1.
   - Load from the same address, with the RAM model returning 0xDEADBEEF → oDM_RVALID at T+3, oDM_RDATA=0xDEADBEEF.
3. **Contention**: both REQs held continuously, data issuing loads, FETCH_MAX_WAIT=4 → 4 data grants, then 1 fetch grant, repeating. The counter reads 0 after each fetch grant.
4. **Misaligned data**: iDM_ADDR=0x0000_0022 → oDM_ERR pulse at T+1, no CE strobe, oBUSY stays 0.
5. **Reset mid-read**: assert iRST during RWAIT → no RVALID issued, oIF_RDATA=0.
6. **Wrap**: fetch at 0x0000_0400 → oRAM_ADDR=0x00. Fetch at 0x0000_03FC → oRAM_ADDR=0xFF.
